// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared pipeline definitions. It holds the control-bundle bit map,
//            the default field widths, and the EX/MEM bundle struct that is
//            reused by the neighbouring pipeline stages.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Control bundle bit map
  localparam int CTRL_MEMWR    = 0;
  localparam int CTRL_BRANCH   = 1;
  localparam int CTRL_JUMP     = 2;
  localparam int CTRL_MEMTOREG = 3;
  localparam int CTRL_REGWR    = 4;
  localparam int CTRL_W        = 5;

  // Default field widths of the EX/MEM bundle
  localparam int EXMEM_DATA_W = 32;
  localparam int EXMEM_RD_W   = 5;

  // Width of the optional performance counters
  localparam int PERF_CNT_W = 32;

  typedef struct packed {
    logic [CTRL_W-1:0]       ctrl;
    logic                    zero;
    logic [EXMEM_RD_W-1:0]   rd;
    logic [EXMEM_DATA_W-1:0] busB;
    logic [EXMEM_DATA_W-1:0] alu;
    logic [EXMEM_DATA_W-1:0] target;
  } exmem_bundle_t;

endpackage
`default_nettype wire

// File: rtl/pipe_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_skid_buf
// Purpose  : Generic WIDTH-bit, 2-entry valid/ready skid buffer with flush.
//            It updates on the falling clock edge. Entry M drives the output.
//            Entry S absorbs one extra word when the consumer stalls, so the
//            upstream ready signal can be a plain register.
// Ports    : clk, rst_n (async, active-low), i_flush,
//            i_valid/o_ready/i_data  - upstream side
//            o_valid/i_ready/o_data  - downstream side
// Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_buf #(
  parameter int               WIDTH          = 8,
  // Bits of the stored words that flush forces to zero
  parameter logic [WIDTH-1:0] FLUSH_CLR_MASK = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic             r_m_valid;
  logic             r_s_valid;
  logic [WIDTH-1:0] r_m_data;
  logic [WIDTH-1:0] r_s_data;
  logic             w_accept;

  // Ready depends only on skid occupancy, so it has no combinational path
  // from i_ready.
  assign w_accept = i_valid && !r_s_valid;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= '0;
      r_s_data  <= '0;
    end else if (i_flush) begin
      // Flush wins over every other event, and any word offered now is lost.
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_data  <= r_m_data & ~FLUSH_CLR_MASK;
      r_s_data  <= r_s_data & ~FLUSH_CLR_MASK;
    end else if (!r_m_valid) begin
      if (w_accept) begin
        r_m_valid <= 1'b1;
        r_m_data  <= i_data;
      end
    end else if (r_s_valid) begin
      // Skid full: the upstream was held off, so only a drain can move data.
      if (i_ready) begin
        r_m_data  <= r_s_data;
        r_s_valid <= 1'b0;
      end
    end else begin
      if (i_ready) begin
        if (w_accept) begin
          r_m_data <= i_data;
        end else begin
          r_m_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_s_data  <= i_data;
        r_s_valid <= 1'b1;
      end
    end
  end

  assign o_ready = ~r_s_valid;
  assign o_valid = r_m_valid;
  assign o_data  = r_m_data;

endmodule
`default_nettype wire

// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_mem_stage
// Purpose  : Elastic EX/MEM pipeline stage. It is a 2-entry skid buffer with
//            flush that updates on the falling clock edge. Control and zero
//            are masked to 0 on bubbles, so MEM never writes on an empty slot.
// Ports    : CLK, Resetn (async, active-low), flush
//            in_valid/in_ready, ctrl_i, zero_i, rd_i, busB_i, alu_i, target_i
//            out_valid/out_ready, ctrl_o, zero_o, rd_o, busB_o, alu_o, target_o
//            stall_cnt_o, flush_cnt_o (only with EX_MEM_STAGE_PERF_EN)
// Options  : `define EX_MEM_STAGE_PERF_EN adds saturating stall/flush counters
// Revision : 1.0 - initial release
// ============================================================================
module ex_mem_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CTRL_W = 5
) (
  input  logic              CLK,
  input  logic              Resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              zero_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic [DATA_W-1:0] busB_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] target_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              zero_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [DATA_W-1:0] busB_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [DATA_W-1:0] target_o
`ifdef EX_MEM_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  localparam int c_w = CTRL_W + 1 + RD_W + 3 * DATA_W;
  // Flush clears the ctrl and zero fields, which sit in the top bits of the
  // packed word. The data fields may keep stale values.
  localparam logic [c_w-1:0] c_clr_mask =
    {{(CTRL_W + 1){1'b1}}, {(c_w - CTRL_W - 1){1'b0}}};

  logic [c_w-1:0]    w_in_data;
  logic [c_w-1:0]    w_out_data;
  logic              w_out_valid;
  logic [CTRL_W-1:0] w_ctrl;
  logic              w_zero;

  assign w_in_data = {ctrl_i, zero_i, rd_i, busB_i, alu_i, target_i};

  pipe_skid_buf #(
    .WIDTH          (c_w),
    .FLUSH_CLR_MASK (c_clr_mask)
  ) u_skid (
    .clk     (CLK),
    .rst_n   (Resetn),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (in_ready),
    .i_data  (w_in_data),
    .o_valid (w_out_valid),
    .i_ready (out_ready),
    .o_data  (w_out_data)
  );

  assign {w_ctrl, w_zero, rd_o, busB_o, alu_o, target_o} = w_out_data;

  assign out_valid = w_out_valid;
  assign ctrl_o    = w_out_valid ? w_ctrl : '0;
  assign zero_o    = w_out_valid & w_zero;

`ifdef EX_MEM_STAGE_PERF_EN
  logic [PERF_CNT_W-1:0] r_stall_cnt;
  logic [PERF_CNT_W-1:0] r_flush_cnt;

  // If M is empty, S is also empty, so out_valid tells us whether a flush
  // kills anything.
  always_ff @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_out_valid && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (flush && w_out_valid && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_mem_stage
// Purpose  : Self-checking bench for ex_mem_stage. A queue-based reference
//            model and a per-cycle compare process check the DUT, alongside
//            directed scenarios with literal expectations and random traffic.
// Options  : honours EX_MEM_STAGE_PERF_EN (counter ports and checks)
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 5;

  logic          CLK = 1'b0;
  logic          Resetn = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] ctrl_i = '0;
  logic          zero_i = 1'b0;
  logic [RW-1:0] rd_i = '0;
  logic [DW-1:0] busB_i = '0;
  logic [DW-1:0] alu_i = '0;
  logic [DW-1:0] target_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] ctrl_o;
  logic          zero_o;
  logic [RW-1:0] rd_o;
  logic [DW-1:0] busB_o;
  logic [DW-1:0] alu_o;
  logic [DW-1:0] target_o;
`ifdef EX_MEM_STAGE_PERF_EN
  logic [31:0]   stall_cnt_o;
  logic [31:0]   flush_cnt_o;
`endif

  ex_mem_stage #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW)) dut (
    .CLK       (CLK),
    .Resetn    (Resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl_i    (ctrl_i),
    .zero_i    (zero_i),
    .rd_i      (rd_i),
    .busB_i    (busB_i),
    .alu_i     (alu_i),
    .target_i  (target_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctrl_o    (ctrl_o),
    .zero_o    (zero_o),
    .rd_o      (rd_o),
    .busB_o    (busB_o),
    .alu_o     (alu_o),
    .target_o  (target_o)
`ifdef EX_MEM_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a FIFO of at most two bundles ----------
  exmem_bundle_t q[$];
  int unsigned   m_stall = 0;
  int unsigned   m_flush = 0;
  bit            m_acc;
  bit            m_drn;

  function automatic exmem_bundle_t cur_in();
    exmem_bundle_t b;
    b.ctrl   = ctrl_i;
    b.zero   = zero_i;
    b.rd     = rd_i;
    b.busB   = busB_i;
    b.alu    = alu_i;
    b.target = target_i;
    return b;
  endfunction

  always @(negedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_acc = in_valid && (q.size() < 2);
      m_drn = (q.size() > 0) && out_ready;
      if ((q.size() > 0) && !out_ready) m_stall++;
      if (flush) begin
        if (q.size() > 0) m_flush++;
        q.delete();
      end else begin
        if (m_drn) void'(q.pop_front());
        if (m_acc) q.push_back(cur_in());
      end
    end
  end

  // ---------------- per-cycle compare on the non-active edge ---------------
  always @(posedge CLK) begin
    check("out_valid", out_valid, q.size() > 0);
    check("in_ready", in_ready, q.size() < 2);
    check("ctrl_o", ctrl_o, (q.size() > 0) ? q[0].ctrl : '0);
    check("zero_o", zero_o, (q.size() > 0) ? q[0].zero : 1'b0);
    if (q.size() > 0)
      check("data_o", {rd_o, busB_o, alu_o, target_o},
            {q[0].rd, q[0].busB, q[0].alu, q[0].target});
`ifdef EX_MEM_STAGE_PERF_EN
    check("stall_cnt_o", stall_cnt_o, m_stall);
    check("flush_cnt_o", flush_cnt_o, m_flush);
`endif
  end

  // Apply one cycle of stimulus, then return on the next rising edge, which
  // is after the falling edge that consumed it.
  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] a,
                       input bit ordy, input bit fl);
    in_valid  = v;
    ctrl_i    = c;
    alu_i     = a;
    zero_i    = a[0];
    rd_i      = a[RW-1:0];
    busB_i    = ~a;
    target_i  = a + 32'h100;
    out_ready = ordy;
    flush     = fl;
    @(posedge CLK);
  endtask

  initial begin
    // Reset held for 3 cycles with live input
    Resetn   = 1'b0;
    in_valid = 1'b1;
    ctrl_i   = 5'h1F;
    alu_i    = 32'hDEAD;
    repeat (3) @(posedge CLK);
    check("rst out_valid", out_valid, 1'b0);
    check("rst ctrl_o", ctrl_o, 5'h0);
    check("rst data", {zero_o, rd_o, busB_o, alu_o, target_o}, '0);
    Resetn = 1'b1;
    #1;
    check("rst in_ready", in_ready, 1'b1);
    @(posedge CLK);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    // Streaming at full rate
    for (int k = 1; k <= 8; k++) begin
      drive(1, 5'h18, k, 1, 0);
      check("stream alu_o", alu_o, k);
      check("stream in_ready", in_ready, 1'b1);
    end
    drive(0, 0, 0, 1, 0);

    // Back-pressure: A is held, B goes to the skid, C is refused
    drive(1, 5'h10, 32'hA, 0, 0);
    drive(1, 5'h10, 32'hB, 0, 0);
    check("bp hold A", alu_o, 32'hA);
    check("bp in_ready low", in_ready, 1'b0);
    drive(1, 5'h10, 32'hC, 0, 0);
    check("bp still A", alu_o, 32'hA);
    drive(1, 5'h10, 32'hC, 1, 0);
    check("bp then B", alu_o, 32'hB);
    check("bp in_ready high", in_ready, 1'b1);
    drive(1, 5'h10, 32'hC, 1, 0);
    check("bp then C", alu_o, 32'hC);
    drive(0, 0, 0, 1, 0);
    check("bp drained", out_valid, 1'b0);

    // Flush with the skid full
    drive(1, 5'b10001, 32'h10, 0, 0);
    drive(1, 5'b10001, 32'h11, 0, 0);
    check("fl full", in_ready, 1'b0);
    drive(1, 5'b10001, 32'h12, 0, 1);
    check("fl out_valid", out_valid, 1'b0);
    check("fl ctrl_o", ctrl_o, 5'h0);
    check("fl in_ready", in_ready, 1'b1);
    drive(0, 0, 0, 1, 0);
    check("fl no reappear", out_valid, 1'b0);

    // Flush drops an input that was accepted in the same cycle
    drive(1, 5'b10001, 32'h20, 1, 0);
    drive(1, 5'b10001, 32'h21, 1, 1);
    check("fl acc out_valid", out_valid, 1'b0);
    drive(0, 0, 0, 1, 0);
    check("fl acc dropped", out_valid, 1'b0);

    // Async reset between clock edges
    drive(1, 5'h1F, 32'h30, 0, 0);
    drive(1, 5'h1F, 32'h31, 0, 0);
    #2 Resetn = 1'b0;
    #1;
    check("arst out_valid", out_valid, 1'b0);
    check("arst ctrl_o", ctrl_o, 5'h0);
    check("arst alu_o", alu_o, 32'h0);
    check("arst in_ready", in_ready, 1'b1);
    @(posedge CLK);
    Resetn = 1'b1;

    // Counters: 4 stall edges, one effective flush, then one empty flush
    drive(1, 5'h11, 32'h40, 0, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1);
`ifdef EX_MEM_STAGE_PERF_EN
    check("perf stall", stall_cnt_o, 32'd4);
    check("perf flush", flush_cnt_o, 32'd1);
`endif
    drive(0, 0, 0, 0, 1);
`ifdef EX_MEM_STAGE_PERF_EN
    check("perf flush empty", flush_cnt_o, 32'd1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, CW'($urandom), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
Parametrised, elastic EX/MEM pipeline stage. It replaces the fixed negedge EX/MEM latch with a valid/ready handshake stage that has a 2-entry skid buffer. The buffer gives full throughput under back-pressure. The stage also supports flush (branch/jump squash) and bubble masking of control signals. It sits between the ALU/branch-target logic (EX) and data memory (MEM).

Parameters:
- DATA_W, 32, width of busB, ALUout and Target.
- RD_W, 5, width of destination register index.
- CTRL_W, 5, width of control bundle. Bit map: [0] MemWr, [1] Branch, [2] Jump, [3] MemtoReg, [4] Regwr.

Ports:
- CLK  in  1  stage clock; all state updates on the falling edge, matching the rest of the pipeline.
- Resetn  in  1  asynchronous, active-low reset.
- flush  in  1  squash every entry held in the stage.
- in_valid  in  1  EX presents a valid bundle.
- in_ready  out  1  stage can accept a bundle.
- ctrl_i  in  CTRL_W  control bundle from EX.
- zero_i  in  1  ALU zero flag.
- rd_i  in  RD_W  destination register index.
- busB_i  in  DATA_W  store data.
- alu_i  in  DATA_W  ALU result.
- target_i  in  DATA_W  branch/jump target.
- out_valid  out  1  MEM-side bundle valid.
- out_ready  in  1  MEM accepts the bundle.
- ctrl_o  out  CTRL_W  control bundle; forced 0 when out_valid=0.
- zero_o  out  1  zero flag; forced 0 when out_valid=0.
- rd_o  out  RD_W  destination index.
- busB_o  out  DATA_W  store data.
- alu_o  out  DATA_W  ALU result.
- target_o  out  DATA_W  target.

Behaviour:
- Storage: main entry M (drives outputs) and skid entry S. Each entry has a valid bit.
- Reset (Resetn=0, asynchronous): both valid bits, all stored fields and all outputs = 0. in_ready = 1 once Resetn rises.
- in_ready = !S.valid. It is registered, with no combinational path from out_ready.
- Accept = in_valid && in_ready. Drain = out_valid && out_ready.
- Next-state rules, evaluated on each falling edge (S.valid=1 implies M.valid=1):
  - M empty, accept: load M. Latency is 1 edge from accept to out_valid.
  - M full, drain, no accept, S empty: M empties.
  - M full, drain, accept, S empty: M loads the input. Throughput is 1 per cycle.
  - M full, no drain, accept: load S. in_ready falls.
  - S full, drain: M <- S and S empties. in_ready rises. in_valid is ignored in this cycle, because in_ready was 0.
  - S full, no drain: hold everything.
- Ordering is strictly FIFO. No bundle is duplicated or dropped except by flush.
- Flush has priority over every other event on that edge. Both valid bits clear and stored ctrl/zero clear. Data fields may hold stale values. The input presented in that cycle is discarded even if accepted. in_ready = 1 on the next cycle.
- Bubble masking: ctrl_o and zero_o are 0 whenever out_valid=0, so MEM never writes memory or the register file on a bubble. Data outputs are not masked.
- Reset asserted mid-operation: all state clears immediately, independent of CLK.
- No arithmetic is performed; all fields pass through at full width.

Optional Feature:
- Macro EX_MEM_STAGE_PERF_EN.
- Defined: adds two 32-bit saturating counters with read-only outputs.
  - stall_cnt_o counts edges where out_valid && !out_ready.
  - flush_cnt_o counts edges where flush kills at least one valid entry.
  - Both reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: no counters and no counter ports. Behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - constants CTRL_MEMWR=0, CTRL_BRANCH=1, CTRL_JUMP=2, CTRL_MEMTOREG=3, CTRL_REGWR=4, CTRL_W=5;
  - a packed struct type exmem_bundle_t {ctrl, zero, rd, busB, alu, target}, used for M, S and port grouping in the IDEX/MEMWB successors.
- One natural sub-module: pipe_skid_buf, a generic WIDTH-bit 2-entry skid buffer with flush. ex_mem_stage wraps it, concatenating the fields and applying bubble masking.

Test Plan:
- Reset: hold Resetn=0 for 3 cycles with in_valid=1 and ctrl_i=5'h1F -> out_valid=0, ctrl_o=0, all outputs 0, in_ready=1 after release.
- Streaming: out_ready=1, inject alu_i=1..8 on consecutive cycles -> alu_o shows 1..8 one edge later each, no gaps, in_ready stays 1.
- Back-pressure: out_ready=0 after the first bundle (alu=0xA), send 0xB and 0xC -> 0xA held, 0xB in skid, in_ready=0, 0xC refused and held by the source. Then out_ready=1 -> order A, B, C with no loss.
- Flush with skid full: ctrl=5'b10001 in both entries, pulse flush while in_valid=1 -> next edge out_valid=0, ctrl_o=0, in_ready=1, flushed input never appears.
- Async reset mid-stream: drop Resetn between clock edges -> outputs clear without a CLK edge.
- With EX_MEM_STAGE_PERF_EN: stall 4 cycles, then one flush of a valid entry -> stall_cnt_o=4, flush_cnt_o=1. A flush of an empty stage leaves flush_cnt_o unchanged.
